// File: rtl/tag_lookup_if.sv
// Handshake and array bundle between the tag lookup controller
// and its requester, memory and 8-way tag array.
interface tag_lookup_if #(
  parameter int TAG_W = 24
);
  logic               req_valid;
  logic               req_ready;
  logic [TAG_W-1:0]   req_tag;
  logic               resp_valid;
  logic               resp_hit;
  logic [2:0]         resp_way;
  logic               resp_err;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [TAG_W-1:0]   mem_req_tag;
  logic               mem_ack;
  logic [7:0]         tag_we;
  logic [TAG_W-1:0]   tag_wdata;
  logic [8*TAG_W-1:0] tag_rd;

  modport master (
    input  req_valid, req_tag,
    input  mem_req_ready, mem_ack, tag_rd,
    output req_ready,
    output resp_valid, resp_hit, resp_way, resp_err,
    output mem_req_valid, mem_req_tag,
    output tag_we, tag_wdata
  );

  modport slave (
    output req_valid, req_tag,
    output mem_req_ready, mem_ack, tag_rd,
    input  req_ready,
    input  resp_valid, resp_hit, resp_way, resp_err,
    input  mem_req_valid, mem_req_tag,
    input  tag_we, tag_wdata
  );
endinterface

// File: rtl/tag_lookup_ctrl.sv
// Lookup/fill controller for an 8-way tag array: hit detection,
// miss fetch with timeout, victim selection (invalid-first, then PLRU).
module tag_lookup_ctrl #(
  parameter int TAG_W   = 24,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  tag_lookup_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, CMP, MREQ, MWAIT, FILL, RESP
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t           state;
  logic [7:0]       valid;
  logic [6:0]       plru;
  logic [7:0]       timer;
  logic [TAG_W-1:0] tag_q;
  logic [2:0]       victim;

  logic [7:0] hit;
  logic [2:0] hit_way;
  logic [2:0] inv_way;
  logic [2:0] plru_way;
  logic [2:0] leaf;
  logic [7:0] timer_nx;

  function automatic logic [6:0] plru_upd(
    input logic [6:0] p,
    input logic [2:0] w
  );
    logic [6:0] n;
    n = p;
    n[0] = ~w[2];
    if (w[2]) n[2] = ~w[1];
    else      n[1] = ~w[1];
    n[3'd3 + {1'b0, w[2:1]}] = ~w[0];
    return n;
  endfunction

  always_comb begin
    hit     = '0;
    hit_way = '0;
    inv_way = '0;
    for (int i = 0; i < 8; i++)
      hit[i] = valid[i] &
        (bus.tag_rd[i*TAG_W +: TAG_W] == tag_q);
    // descending scan leaves the lowest index
    for (int i = 7; i >= 0; i--) begin
      if (hit[i])    hit_way = 3'(i);
      if (!valid[i]) inv_way = 3'(i);
    end
  end

  always_comb begin
    plru_way[2] = plru[0];
    plru_way[1] = plru[0] ? plru[2] : plru[1];
    leaf        = 3'd3 + {1'b0, plru_way[2:1]};
    plru_way[0] = plru[leaf];
    timer_nx    = timer + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      valid             <= '0;
      plru              <= '0;
      timer             <= '0;
      tag_q             <= '0;
      victim            <= '0;
      bus.req_ready     <= 1'b0;
      bus.resp_valid    <= 1'b0;
      bus.resp_hit      <= 1'b0;
      bus.resp_way      <= '0;
      bus.resp_err      <= 1'b0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_tag   <= '0;
      bus.tag_we        <= '0;
      bus.tag_wdata     <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_hit   <= 1'b0;
      bus.resp_way   <= '0;
      bus.resp_err   <= 1'b0;
      bus.tag_we     <= '0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            tag_q         <= bus.req_tag;
            bus.req_ready <= 1'b0;
            state         <= CMP;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        CMP: begin
          if (|hit) begin
            bus.resp_valid <= 1'b1;
            bus.resp_hit   <= 1'b1;
            bus.resp_way   <= hit_way;
            plru           <= plru_upd(plru, hit_way);
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end else begin
            victim            <= (&valid) ? plru_way : inv_way;
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_tag   <= tag_q;
            state             <= MREQ;
          end
        end
        MREQ: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            timer             <= '0;
            state             <= MWAIT;
          end
        end
        MWAIT: begin
          if (bus.mem_ack) begin
            bus.tag_we    <= 8'b1 << victim;
            bus.tag_wdata <= tag_q;
            state         <= FILL;
          end else begin
            timer <= timer_nx;
            // abort after TIMEOUT cycles spent here
            if (timer_nx == TMO) begin
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_way   <= victim;
              bus.req_ready  <= 1'b1;
              state          <= IDLE;
            end
          end
        end
        FILL: begin
          valid[victim]  <= 1'b1;
          plru           <= plru_upd(plru, victim);
          bus.resp_valid <= 1'b1;
          bus.resp_way   <= victim;
          state          <= RESP;
        end
        RESP: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Directed bench for tag_lookup_ctrl with a behavioural
// 8-way tag array written on the falling edge.
module tb_tag_lookup_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [23:0] arr [8];
  logic        r_hit;
  logic [2:0]  r_way;
  logic        r_err;
  logic [7:0]  we;
  int          lat;
  int          mw;
  int          seen;

  tag_lookup_if #(.TAG_W(24)) bus ();

  tag_lookup_ctrl #(.TAG_W(24), .TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (reset) arr[i] <= '0;
      else if (bus.tag_we[i]) arr[i] <= bus.tag_wdata;
    end
  end

  always_comb begin
    bus.tag_rd = '0;
    for (int i = 0; i < 8; i++)
      bus.tag_rd[i*24 +: 24] = arr[i];
  end

  task automatic check(input string nm,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic check_idle_outs(input string nm);
    check({nm, "_rvalid"}, 32'(bus.resp_valid), 0);
    check({nm, "_rhit"},   32'(bus.resp_hit), 0);
    check({nm, "_rway"},   32'(bus.resp_way), 0);
    check({nm, "_rerr"},   32'(bus.resp_err), 0);
    check({nm, "_mvalid"}, 32'(bus.mem_req_valid), 0);
    check({nm, "_mtag"},   32'(bus.mem_req_tag), 0);
    check({nm, "_we"},     32'(bus.tag_we), 0);
    check({nm, "_wdata"},  32'(bus.tag_wdata), 0);
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check({nm, "_rdy"}, 32'(bus.req_ready), 0);
    check_idle_outs(nm);
    reset = 1'b0;
  endtask

  // One request; answers memory, optionally stalls mem_req_ready.
  task automatic txn(input logic [23:0] tag, input bit ack,
                     input int stall, input string nm);
    int  hs_c;
    int  left;
    bit  done;
    we = '0; lat = 0; mw = -1; hs_c = -1;
    left = stall; done = 1'b0;
    r_hit = 1'bx; r_way = 'x; r_err = 1'bx;
    for (int k = 0; k < 20 && !bus.req_ready; k++) begin
      @(posedge clk); #1;
    end
    check({nm, "_rdy"}, 32'(bus.req_ready), 1);
    bus.req_valid     = 1'b1;
    bus.req_tag       = tag;
    bus.mem_req_ready = (stall == 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int c = 1; c < 400 && !done; c++) begin
      @(posedge clk); #1;
      bus.mem_ack   = 1'b0;
      bus.req_valid = 1'b0;
      if (bus.tag_we != 0) we = bus.tag_we;
      if (bus.resp_valid) begin
        lat   = c;
        r_hit = bus.resp_hit;
        r_way = bus.resp_way;
        r_err = bus.resp_err;
        if (hs_c >= 0) mw = c - hs_c - 1;
        done  = 1'b1;
      end else if (hs_c >= 0 && c == hs_c + 1) begin
        bus.mem_ack = ack;
      end else if (hs_c < 0 &&
                   (bus.mem_req_valid || left < stall)) begin
        check({nm, "_mvalid"}, 32'(bus.mem_req_valid), 1);
        check({nm, "_mtag"}, 32'(bus.mem_req_tag), 32'(tag));
        if (left > 0) begin
          check({nm, "_stall_rdy"}, 32'(bus.req_ready), 0);
          left--;
          bus.req_valid = left[0];
          bus.req_tag   = 24'h5A5A5A;
        end
        bus.mem_req_ready = (left == 0);
        if (bus.mem_req_ready) hs_c = c;
      end
    end
    if (!done) check({nm, "_no_resp"}, 0, 1);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_tag = '0;
    bus.mem_req_ready = 1'b0; bus.mem_ack = 1'b0;

    do_reset("rst0");

    txn(24'hABCDEF, 1'b1, 0, "t1");
    check("t1_we",  32'(we), 32'h01);
    check("t1_hit", 32'(r_hit), 0);
    check("t1_way", 32'(r_way), 0);
    check("t1_err", 32'(r_err), 0);

    do_reset("rst1");
    for (int i = 1; i <= 8; i++) begin
      txn(24'(i), 1'b1, 0, "t2_fill");
      check("t2_fill_we",  32'(we), 32'(1) << (i - 1));
      check("t2_fill_way", 32'(r_way), 32'(i - 1));
      check("t2_fill_hit", 32'(r_hit), 0);
    end
    txn(24'd5, 1'b1, 0, "t2_hit");
    check("t2_hit",  32'(r_hit), 1);
    check("t2_way",  32'(r_way), 4);
    check("t2_lat",  32'(lat), 1);
    check("t2_we",   32'(we), 0);

    txn(24'd9, 1'b1, 0, "t3a");
    check("t3a_we",  32'(we), 32'h01);
    check("t3a_way", 32'(r_way), 0);
    txn(24'd1, 1'b1, 0, "t3b");
    check("t3b_hit", 32'(r_hit), 0);
    check("t3b_we",  32'(we), 32'h40);
    txn(24'd9, 1'b1, 0, "t3c");
    check("t3c_hit", 32'(r_hit), 1);
    check("t3c_way", 32'(r_way), 0);

    txn(24'h000100, 1'b0, 0, "t4a");
    check("t4a_err", 32'(r_err), 1);
    check("t4a_hit", 32'(r_hit), 0);
    check("t4a_way", 32'(r_way), 5);
    check("t4a_we",  32'(we), 0);
    check("t4a_mw",  32'(mw), 255);
    txn(24'h000100, 1'b1, 0, "t4b");
    check("t4b_hit", 32'(r_hit), 0);
    check("t4b_err", 32'(r_err), 0);
    check("t4b_we",  32'(we), 32'h20);

    txn(24'h000200, 1'b1, 10, "t5");
    check("t5_hit", 32'(r_hit), 0);
    check("t5_way", 32'(r_way), 2);
    check("t5_we",  32'(we), 32'h04);

    for (int k = 0; k < 20 && !bus.req_ready; k++) begin
      @(posedge clk); #1;
    end
    bus.mem_req_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_tag   = 24'h000300;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 0; k < 10 && !bus.mem_req_valid; k++) begin
      @(posedge clk); #1;
    end
    check("t6_mreq", 32'(bus.mem_req_valid), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle_outs("t6_rst");
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.resp_valid || bus.tag_we != 0) seen++;
    end
    check("t6_quiet", 32'(seen), 0);
    check("t6_rdy",   32'(bus.req_ready), 1);
    txn(24'd9, 1'b1, 0, "t6_re");
    check("t6_re_hit", 32'(r_hit), 0);
    check("t6_re_we",  32'(we), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
